// File: rtl/carry_in_gen_if.sv
// Bus bundle for the carry-in generator: CE/control inputs, carry sources and per-lane results.
// The master side drives sources and controls; the slave side (the generator) returns cin and error status.
interface carry_in_gen_if #(
    parameter int LANES = 1
);
    logic             ce_carryin;
    logic             ce_ctrl;
    logic             clr_err;
    logic [2:0]       carryinsel;
    logic             carryin;
    logic             pcin_msb;
    logic             carrycascin;
    logic             carrycascout;
    logic [LANES-1:0] lane_cout_fb;
    logic             p_msb;
    logic             a_msb;
    logic             b_msb;
    logic [LANES-1:0] cin;
    logic             sel_illegal;
    logic             err_sticky;

    modport master (
        output ce_carryin, ce_ctrl, clr_err, carryinsel, carryin, pcin_msb,
               carrycascin, carrycascout, lane_cout_fb, p_msb, a_msb, b_msb,
        input  cin, sel_illegal, err_sticky
    );

    modport slave (
        input  ce_carryin, ce_ctrl, clr_err, carryinsel, carryin, pcin_msb,
               carrycascin, carrycascout, lane_cout_fb, p_msb, a_msb, b_msb,
        output cin, sel_illegal, err_sticky
    );
endinterface

// File: rtl/carry_in_gen.sv
// DSP48E1-style post-adder carry-in generator: 8-way carry source select, SIMD lane
// distribution, configurable carryin / select / mult-sign registering and a sticky illegal-select flag.
module carry_in_gen #(
    parameter int LANES         = 1,  // 1 = ONE48, 2 = TWO24, 4 = FOUR12
    parameter int CARRYIN_DEPTH = 1,  // 0, 1 or 2 stages on the fabric carryin path
    parameter int SEL_REG       = 1,  // 0 = combinational select, 1 = registered
    parameter int MULT_SIGN_REG = 1   // 0 or 1 stage on the rounding term
) (
    input  logic           clk,
    input  logic           rst,
    carry_in_gen_if.slave  bus
);

    typedef enum logic [2:0] {
        SRC_CARRYIN = 3'b000,
        SRC_PCIN    = 3'b001,
        SRC_CASCIN  = 3'b010,
        SRC_PCIN_N  = 3'b011,
        SRC_CASCOUT = 3'b100,
        SRC_P       = 3'b101,
        SRC_XS      = 3'b110,
        SRC_P_N     = 3'b111
    } src_e;

    logic             w_carryin_d;
    logic             w_xs;
    logic             w_xs_d;
    src_e             w_esel;
    logic             w_lane0;
    logic             w_sign_src;
    logic             w_sel_illegal;
    logic [LANES-1:0] w_cin;
    logic             r_err;
    logic             w_unused;

    // Lane 0 takes its feedback from carrycascout, so lane_cout_fb[0] has no consumer;
    // the CE inputs may also be unused in some parameter combinations.
    assign w_unused = ^{bus.lane_cout_fb[0], bus.ce_ctrl, bus.ce_carryin};

    // ------------------------------------------------------------------
    // Fabric carryin delay line
    // ------------------------------------------------------------------
    if (CARRYIN_DEPTH == 0) begin : g_cin_comb
        assign w_carryin_d = bus.carryin;
    end else begin : g_cin_pipe
        logic [CARRYIN_DEPTH-1:0] r_pipe;

        // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the
        // clocked branch and no async sensitivity is listed; state uses <= so every stage
        // reads the pre-edge value of its neighbour and the line shifts exactly one place.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_pipe <= '0;
            end else if (bus.ce_carryin) begin
                r_pipe[0] <= bus.carryin;
                for (int i = 1; i < CARRYIN_DEPTH; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign w_carryin_d = r_pipe[CARRYIN_DEPTH-1];
    end

    // ------------------------------------------------------------------
    // Multiplier-sign rounding term ~(A[24] ^ B[17])
    // ------------------------------------------------------------------
    assign w_xs = ~(bus.a_msb ^ bus.b_msb);

    if (MULT_SIGN_REG == 0) begin : g_xs_comb
        assign w_xs_d = w_xs;
    end else begin : g_xs_reg
        logic r_xs;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_xs <= 1'b0;
            end else if (bus.ce_carryin) begin
                r_xs <= w_xs;
            end
        end

        assign w_xs_d = r_xs;
    end

    // ------------------------------------------------------------------
    // Effective select
    // ------------------------------------------------------------------
    if (SEL_REG == 0) begin : g_sel_comb
        assign w_esel = src_e'(bus.carryinsel);
    end else begin : g_sel_reg
        logic [2:0] r_sel;

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_sel <= 3'b000;
            end else if (bus.ce_ctrl) begin
                r_sel <= bus.carryinsel;
            end
        end

        assign w_esel = src_e'(r_sel);
    end

    // ------------------------------------------------------------------
    // Lane 0 source mux
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before the case, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_lane0 = 1'b0;
        unique case (w_esel)
            SRC_CARRYIN: w_lane0 = w_carryin_d;
            SRC_PCIN:    w_lane0 = bus.pcin_msb;
            SRC_CASCIN:  w_lane0 = bus.carrycascin;
            SRC_PCIN_N:  w_lane0 = ~bus.pcin_msb;
            SRC_CASCOUT: w_lane0 = bus.carrycascout;
            SRC_P:       w_lane0 = bus.p_msb;
            SRC_XS:      w_lane0 = w_xs_d;
            SRC_P_N:     w_lane0 = ~bus.p_msb;
            default:     w_lane0 = 1'b0;
        endcase
    end

    // Sign-derived sources only make sense for a full 48-bit ALU, so SIMD modes reject them.
    assign w_sign_src = (w_esel == SRC_PCIN)   || (w_esel == SRC_PCIN_N) ||
                        (w_esel == SRC_P)      || (w_esel == SRC_P_N)    ||
                        (w_esel == SRC_XS);
    assign w_sel_illegal = (LANES > 1) && w_sign_src;

    // ------------------------------------------------------------------
    // Per-lane carry-in
    // ------------------------------------------------------------------
    always_comb begin
        w_cin = '0;
        if (!w_sel_illegal) begin
            w_cin[0] = w_lane0;
            for (int k = 1; k < LANES; k++) begin
                w_cin[k] = (w_esel == SRC_CASCOUT) ? bus.lane_cout_fb[k] : 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky error: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_sel_illegal) begin
            r_err <= 1'b1;
        end else if (bus.clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign bus.cin         = w_cin;
    assign bus.sel_illegal = w_sel_illegal;
    assign bus.err_sticky  = r_err;

endmodule
